hilo_muldiv_ctrl: RTL
=====================

# hilo_muldiv_ctrl

Multi-cycle multiply/divide sequencer that owns the HI/LO register pair for the MIPS CPU datapath. It replaces single-cycle combinational `*`, `/` and `%` with a radix-2 iterative engine, one bit per cycle. It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO. It raises a stall to the pipeline when an MFHI/MFLO or a new HI/LO operation arrives while a computation is in flight.

## Interface
- `ITER`, 32: iterations per multiply/divide; equals operand width.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  single-cycle operation request; sampled only when `busy`=0.
- `op`  in  3  operation code: MULT, MULTU, DIV, DIVU, MTHI, MTLO.
- `a`  in  32  rs operand: dividend or multiplicand, or the MTHI/MTLO data.
- `b`  in  32  rt operand: divisor or multiplier.
- `mf_req`  in  1  decode stage holds MFHI/MFLO.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle pulse in the cycle after HI/LO are written by MULT/DIV.
- `stall`  out  1  `busy & (start | mf_req)`; combinational.

## Operation
- States:
  - IDLE: start & MULT/MULTU/DIV/DIVU → LOAD; start & MTHI/MTLO → write `a` to `hi`/`lo`, stay IDLE, no `done`.
  - LOAD: latch operand magnitudes (signed ops) or raw values (unsigned ops), sign flags and op. Clear counter and accumulators. → RUN. Exception: divisor == 0 → FIX, with HI and LO forced as defined below.
  - RUN: one shift-add (multiply) or one restoring shift-subtract (divide) step per cycle. Counter 0..ITER-1; → FIX when counter == ITER-1.
  - FIX: apply signs, write `hi`/`lo`, assert `done` next cycle → IDLE.
- Multiply: 64-bit unsigned product of magnitudes. MULT negates the 64-bit result (two's complement) when `a[31]^b[31]`.
- Divide: unsigned quotient and remainder of magnitudes. DIV negates the quotient when `a[31]^b[31]` and the remainder when `a[31]`. LO = quotient, HI = remainder.
- 0x80000000 / 0xFFFFFFFF (DIV): LO=0x80000000, HI=0; the result wraps and no exception is raised.
- Divide by zero (DIV or DIVU): HI = `a` unmodified, LO = 0xFFFFFFFF.
- `start` while `busy`=1 is ignored and raises `stall`; the requester must hold it until accepted.
- `hi`/`lo` keep their previous values until FIX, so a stalled MF never reads a partial result.

## Timing
- Reset, asynchronous: state=IDLE, `hi`=0, `lo`=0, `done`=0, counter=0. `busy`=0 and `stall`=0 follow. Any in-flight operation is discarded.
- MULT/DIV accepted at edge E0, which enters LOAD:
  - RUN edges are E2..E33.
  - FIX is written at edge E34.
  - `done`=1 for the cycle following E34.
  - `busy`=1 from after E0 through E34.
  - Latency is 35 cycles.
- Divide by zero: FIX at E2, latency 3.
- MTHI/MTLO: register updated at the accepting edge; latency 1; `busy` stays 0.
- A `start` in the same cycle that `done` is high is accepted, because state is IDLE.

## Configuration
- `HILO_FAST_MULT_EN`:
  - Defined: MULT/MULTU compute the full 64-bit product combinationally in LOAD and go straight to FIX. Latency 3, `done` after E2.
  - Undefined: iterative multiply as specified above.
  - Divide is iterative in both builds.

## Structure
- `muldiv_pkg` holds:
  - `muldiv_op_t` enum: MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5.
  - `muldiv_state_t` enum: IDLE, LOAD, RUN, FIX.
  - The `ITER` default and the divide-by-zero LO constant 0xFFFFFFFF.
- Sub-module `muldiv_step`: combinational single iteration. Takes the accumulator, operand register and mode; returns the next accumulator and operand register. It is instantiated once inside `hilo_muldiv_ctrl`.

## Test plan
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → after 35 cycles HI=0xFFFFFFFE, LO=0x00000001, `done` pulses once.
- MULT a=0xFFFFFFFD (-3), b=7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB. DIV a=0xFFFFFFF9 (-7), b=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU a=0x12345678, b=0 → HI=0x12345678, LO=0xFFFFFFFF after 3 cycles. DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- MULTU 5×6 running, then `mf_req`=1 and a second `start` (DIVU 100/7) at cycle 5:
  - `stall`=1 until `done`.
  - HI/LO stay at their prior values, then become 0/30.
  - The held DIVU is accepted in the `done` cycle and yields LO=14, HI=2.
- MTLO a=0xCAFEBABE → `lo`=0xCAFEBABE at the next edge, `busy` stays 0. Assert `reset` at cycle 10 of a MULT → immediately `busy`=0, `hi`=`lo`=0, no `done`.
- `HILO_FAST_MULT_EN` build: MULTU 0x10000×0x10000 → HI=1, LO=0 with `done` 3 cycles after accept.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the HI/LO multiply/divide sequencer.
package muldiv_pkg;

  typedef enum logic [2:0] {
    MULT  = 3'd0,
    MULTU = 3'd1,
    DIV   = 3'd2,
    DIVU  = 3'd3,
    MTHI  = 3'd4,
    MTLO  = 3'd5
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    FIX
  } muldiv_state_t;

  localparam int          ITER_DEF = 32;
  localparam logic [31:0] DZ_LO    = 32'hFFFF_FFFF;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract for divide.
// acc is the upper half of the working pair, opr the lower half (multiplier/quotient).
module muldiv_step (
  input  logic        is_div,
  input  logic [31:0] acc,
  input  logic [31:0] opr,
  input  logic [31:0] m,
  output logic [31:0] acc_nxt,
  output logic [31:0] opr_nxt
);

  logic [32:0] sum;
  logic [32:0] sh;
  logic [31:0] rem;
  logic        ge;

  always_comb begin
    sum = {1'b0, acc} + (opr[0] ? {1'b0, m} : 33'd0);
    sh  = {acc, opr[31]};
    ge  = (sh >= {1'b0, m});
    // partial remainder stays below m, so the difference always fits in 32 bits
    rem = sh[31:0] - m;
    if (is_div) begin
      acc_nxt = ge ? rem : sh[31:0];
      opr_nxt = {opr[30:0], ge};
    end else begin
      acc_nxt = sum[32:1];
      opr_nxt = {sum[0], opr[31:1]};
    end
  end

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO owner with an iterative multiply/divide engine and pipeline stall generation.
// Build option HILO_FAST_MULT_EN: single-cycle multiply in LOAD instead of iterating.
//
// state | meaning
// IDLE  | accept new op; MTHI/MTLO write immediately
// LOAD  | form operand magnitudes, clear counter; divide-by-zero goes to FIX
// RUN   | one iteration per cycle, ITER cycles
// FIX   | apply signs, write HI/LO, pulse done next cycle
module hilo_muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int ITER = ITER_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        mf_req,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        stall
);

  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

  muldiv_state_t state_q, state_d;
  muldiv_op_t    op_q, op_d;
  logic [31:0]   a_q, a_d, b_q, b_d, m_q, m_d;
  logic [31:0]   acc_q, acc_d, opr_q, opr_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dz_q, dz_d, done_q, done_d;

  logic          is_div, is_signed;
  logic [31:0]   mag_a, mag_b, step_acc, step_opr;
  logic [63:0]   prod;

  muldiv_step u_step (
    .is_div  (is_div),
    .acc     (acc_q),
    .opr     (opr_q),
    .m       (m_q),
    .acc_nxt (step_acc),
    .opr_nxt (step_opr)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    m_d     = m_q;
    acc_d   = acc_q;
    opr_d   = opr_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    dz_d    = dz_q;
    done_d  = 1'b0;

    is_div    = (op_q == DIV) || (op_q == DIVU);
    is_signed = (op_q == MULT) || (op_q == DIV);
    mag_a     = (is_signed && a_q[31]) ? -a_q : a_q;
    mag_b     = (is_signed && b_q[31]) ? -b_q : b_q;
    prod      = {acc_q, opr_q};

    case (state_q)
      IDLE: begin
        if (start) begin
          case (op)
            MULT, MULTU, DIV, DIVU: begin
              op_d    = muldiv_op_t'(op);
              a_d     = a;
              b_d     = b;
              state_d = LOAD;
            end
            MTHI:    hi_d = a;
            MTLO:    lo_d = a;
            default: ;
          endcase
        end
      end
      LOAD: begin
        m_d     = mag_b;
        opr_d   = mag_a;
        acc_d   = '0;
        cnt_d   = '0;
        dz_d    = 1'b0;
        state_d = RUN;
        if (is_div && (b_q == 32'd0)) begin
          dz_d    = 1'b1;
          state_d = FIX;
        end
`ifdef HILO_FAST_MULT_EN
        if (!is_div) begin
          {acc_d, opr_d} = {32'd0, mag_a} * {32'd0, mag_b};
          state_d        = FIX;
        end
`endif
      end
      RUN: begin
        acc_d = step_acc;
        opr_d = step_opr;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(ITER - 1)) state_d = FIX;
      end
      FIX: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (dz_q) begin
          hi_d = a_q;
          lo_d = DZ_LO;
        end else if (is_div) begin
          // remainder takes the dividend's sign, quotient the xor of both
          lo_d = (is_signed && (a_q[31] ^ b_q[31])) ? -opr_q : opr_q;
          hi_d = (is_signed && a_q[31]) ? -acc_q : acc_q;
        end else begin
          if (is_signed && (a_q[31] ^ b_q[31])) prod = -prod;
          hi_d = prod[63:32];
          lo_d = prod[31:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= MULT;
      a_q     <= '0;
      b_q     <= '0;
      m_q     <= '0;
      acc_q   <= '0;
      opr_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      opr_q   <= opr_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      dz_q    <= dz_d;
      done_q  <= done_d;
    end
  end

  assign hi    = hi_q;
  assign lo    = lo_q;
  assign done  = done_q;
  assign busy  = (state_q != IDLE);
  assign stall = busy & (start | mf_req);

endmodule
